// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, digit constants and range helper for the BCD converter.
package bcd_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
   localparam logic [3:0] BCD_NINE    = 4'h9;
   localparam logic [3:0] ADD3_THRESH = 4'd5;
   function automatic longint unsigned bcd_max(input int digits);
      longint unsigned m = 64'd1;
      for (int i = 0; i < digits; i++) m = m * 64'd10;
      return m - 64'd1;
   endfunction
endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// bin_to_bcd_converter_if: start/busy/done handshake plus data lines of the BCD converter.
interface bin_to_bcd_converter_if #(parameter int IN_W = 16, parameter int DIGITS = 4);
   logic                  start;
   logic [IN_W-1:0]       bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;
   modport master (output start, bin, input busy, done, bcd, overflow);
   modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble digit correction, adds 3 when the digit is 5 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);
   assign d_o = (d_i >= ADD3_THRESH) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_SATURATE_EN to report all-nines instead of the truncated value on overflow.
module bin_to_bcd_converter
   import bcd_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bin_to_bcd_converter_if.slave   bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam longint unsigned MAX_VAL = bcd_max(DIGITS);

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [IN_W-1:0] shift_q, shift_d;
   logic [W-1:0]    work_q, work_d, adj, bcd_q, bcd_d;
   logic            ovf_next_q, busy_q, done_q, overflow_q, ovf_d, unused_carry;

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adjust u_adj (.d_i(work_q[4*d +: 4]), .d_o(adj[4*d +: 4]));
   end

   // The carry out of the top digit falls off, giving bin mod 10**DIGITS.
   assign {unused_carry, work_d, shift_d} = {adj, shift_q, 1'b0};
   assign ovf_d = 64'(bus.bin) > MAX_VAL;

`ifdef BCD_SATURATE_EN
   assign bcd_d = ovf_next_q ? {DIGITS{BCD_NINE}} : work_d;
`else
   assign bcd_d = work_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         work_q     <= '0;
         ovf_next_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.start) begin
               shift_q    <= bus.bin;
               work_q     <= '0;
               cnt_q      <= '0;
               ovf_next_q <= ovf_d;
               busy_q     <= 1'b1;
               state_q    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               work_q  <= work_d;
               shift_q <= shift_d;
               cnt_q   <= cnt_q + 1'b1;
               // Results are loaded from the final shift so they appear with done.
               if (cnt_q == CW'(IN_W - 1)) begin
                  state_q    <= ST_DONE;
                  done_q     <= 1'b1;
                  bcd_q      <= bcd_d;
                  overflow_q <= ovf_next_q;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: table, corner-case and random checks of the BCD converter.
module tb_bin_to_bcd_converter;
   typedef struct {
      logic [15:0] bin;
      logic [15:0] bcd;
      logic        ovf;
   } vec_t;

`ifdef BCD_SATURATE_EN
   localparam logic [15:0] E_65535 = 16'h9999;
   localparam logic [15:0] E_10000 = 16'h9999;
`else
   localparam logic [15:0] E_65535 = 16'h5535;
   localparam logic [15:0] E_10000 = 16'h0000;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[10];

   bin_to_bcd_converter_if #(.IN_W(16), .DIGITS(4)) bus ();
   bin_to_bcd_converter #(.IN_W(16), .DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [15:0] model_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned x;
      x = v % 10000;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef BCD_SATURATE_EN
      if (v > 9999) r = 16'h9999;
`endif
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One conversion; bin is scrambled right after accept to show it is not re-read.
   task automatic run(input logic [15:0] v, output logic [15:0] r_bcd, output logic r_ovf,
                      output int busy_n, output bit seen, output bit stable, output bit idle_ok);
      logic [15:0] prev;
      @(negedge clk);
      prev = bus.bcd;
      bus.start = 1'b1;
      bus.bin = v;
      @(negedge clk);
      bus.start = 1'b0;
      bus.bin = 16'($urandom);
      busy_n = 0;
      seen = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.bcd !== prev) stable = 1'b0;
         @(negedge clk);
      end
      r_bcd = bus.bcd;
      r_ovf = bus.overflow;
      @(negedge clk);
      idle_ok = !bus.busy && !bus.done;
   endtask

   task automatic conv(input string tag, input logic [15:0] v, input logic [15:0] e_bcd, input logic e_ovf);
      logic [15:0] r_bcd;
      logic        r_ovf;
      int          busy_n;
      bit          seen, stable, idle_ok;
      run(v, r_bcd, r_ovf, busy_n, seen, stable, idle_ok);
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " bcd"}, 32'(r_bcd), 32'(e_bcd));
      chk({tag, " overflow"}, 32'(r_ovf), 32'(e_ovf));
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'd17);
      chk({tag, " bcd_stable"}, 32'(stable), 32'd1);
      chk({tag, " idle_after"}, 32'(idle_ok), 32'd1);
   endtask

   initial begin
      int dn;
      logic [15:0] v;
      tbl[0] = '{16'd1234,  16'h1234, 1'b0};
      tbl[1] = '{16'd0,     16'h0000, 1'b0};
      tbl[2] = '{16'd9999,  16'h9999, 1'b0};
      tbl[3] = '{16'd65535, E_65535,  1'b1};
      tbl[4] = '{16'd10000, E_10000,  1'b1};
      tbl[5] = '{16'd9,     16'h0009, 1'b0};
      tbl[6] = '{16'd10,    16'h0010, 1'b0};
      tbl[7] = '{16'd99,    16'h0099, 1'b0};
      tbl[8] = '{16'd1000,  16'h1000, 1'b0};
      tbl[9] = '{16'd8191,  16'h8191, 1'b0};
      bus.start = 1'b0;
      bus.bin = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset bcd", 32'(bus.bcd), 32'd0);
      chk("reset overflow", 32'(bus.overflow), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) conv($sformatf("tbl%0d", i), tbl[i].bin, tbl[i].bcd, tbl[i].ovf);

      // Starts during the conversion and in the done cycle must be dropped.
      dn = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin = 16'd42;
      @(negedge clk);
      bus.start = 1'b0;
      bus.bin = 16'd777;
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
      dn += int'(bus.done);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dn += int'(bus.done);
      repeat (30) begin
         @(negedge clk);
         dn += int'(bus.done);
      end
      chk("ignore done_count", 32'(dn), 32'd1);
      chk("ignore bcd", 32'(bus.bcd), 32'h0042);
      chk("ignore overflow", 32'(bus.overflow), 32'd0);
      chk("ignore busy", 32'(bus.busy), 32'd0);

      // Reset in the middle of a conversion.
      dn = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin = 16'd1234;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort bcd", 32'(bus.bcd), 32'd0);
      chk("abort overflow", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         dn += int'(bus.done) + int'(bus.busy);
      end
      chk("abort no_done", 32'(dn), 32'd0);
      conv("after_abort", 16'd58, 16'h0058, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         v = 16'($urandom_range(9999));
         conv($sformatf("rnd%0d(%0d)", i, v), v, model_bcd(v), 1'b0);
      end
      for (int i = 0; i < 60; i++) begin
         v = 16'($urandom);
         conv($sformatf("wide%0d(%0d)", i, v), v, model_bcd(v), v > 16'd9999);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
